avalon_irq_aggregator: RTL and testbench

- Avalon-MM slave that collects up to 16 peripheral interrupt lines, such as the interval-timer irq and PIO/UART irqs, into one CPU irq.
- Sits directly downstream of the timer and its sibling peripherals; consumes their irq outputs.
- Each line is sampled, optionally edge-latched, masked and priority-encoded so firmware can find the source in one read.
- Bus side uses the same 16-bit, 3-bit-address, fixed-latency slave style as the timer.

---
 rtl/avalon_irq_aggregator_pkg.sv | 25 ++
 rtl/avalon_irq_aggregator_if.sv | 27 ++
 rtl/irq_prio_enc16.sv | 21 ++
 rtl/avalon_irq_aggregator.sv | 111 +++++++++++
 tb/tb_avalon_irq_aggregator.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/avalon_irq_aggregator_pkg.sv
// Shared constants for the Avalon-MM interrupt aggregator: register map,
// data width and the per-instance implemented-bit mask helper.
package avalon_irq_aggregator_pkg;

   localparam int DATA_W        = 16;
   localparam int N_IRQ_MAX     = 16;
   localparam int ACT_VALID_BIT = 15;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_EDGE    = 3'd2;
   localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
   localparam logic [2:0] ADDR_RAW     = 3'd4;

   // Ones in the low n bits; bits at or above n are never stored.
   function automatic logic [DATA_W-1:0] irq_bit_mask(input int n);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/avalon_irq_aggregator_if.sv
// Avalon-MM slave bus bundle (16-bit data, 3-bit word address, fixed read latency).
interface avalon_irq_aggregator_if;
   import avalon_irq_aggregator_pkg::*;

   logic [2:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

endinterface

// File: rtl/irq_prio_enc16.sv
// Combinational lowest-index priority encoder: 16-bit request vector in,
// 4-bit index of the lowest set bit plus a valid flag out (index 0 when none).
module irq_prio_enc16 (
   input  logic [15:0] req,
   output logic [3:0]  idx,
   output logic        valid
);

   always_comb begin
      idx   = 4'd0;
      valid = 1'b0;
      // Scan high to low so the lowest set bit is the last one to win.
      for (int i = 15; i >= 0; i--) begin
         if (req[i]) begin
            idx   = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/avalon_irq_aggregator.sv
// Avalon-MM interrupt aggregator: samples up to 16 irq lines, level/edge
// latches, masks and priority-encodes them. Macro IRQ_SYNC_EN selects a
// two-flop synchronizer per line instead of a single capture flop.
module avalon_irq_aggregator
   import avalon_irq_aggregator_pkg::*;
#(
   parameter int                N_IRQ      = 8,
   parameter logic [DATA_W-1:0] EDGE_RESET = 16'h0000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   avalon_irq_aggregator_if.slave   bus,
   input  logic [N_IRQ-1:0]         irq_in,
   output logic                     irq
);

   localparam logic [DATA_W-1:0] IMPL_MASK = irq_bit_mask(N_IRQ);

   logic [DATA_W-1:0] irq_in_x;
   logic [DATA_W-1:0] irq_s;
   logic [DATA_W-1:0] irq_prev;
   logic [DATA_W-1:0] rise;
   logic [DATA_W-1:0] pending;
   logic [DATA_W-1:0] pending_nxt;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] edge_sel;
   logic [DATA_W-1:0] w1c;
   logic [DATA_W-1:0] masked;
   logic [DATA_W-1:0] rd_mux;
   logic [3:0]        act;
   logic              act_valid;
   logic              wr_en;

   assign irq_in_x = DATA_W'(irq_in);

   // Input sampling stage
`ifdef IRQ_SYNC_EN
   logic [DATA_W-1:0] irq_sync_p0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_sync_p0 <= '0;
         irq_s       <= '0;
      end else begin
         irq_sync_p0 <= irq_in_x & IMPL_MASK;
         irq_s       <= irq_sync_p0;
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_s <= '0;
      else          irq_s <= irq_in_x & IMPL_MASK;
   end
`endif

   assign rise   = irq_s & ~irq_prev;
   assign wr_en  = bus.chipselect & ~bus.write_n;
   assign w1c    = (wr_en && bus.address == ADDR_PENDING) ? (bus.writedata & edge_sel) : '0;
   assign masked = pending & mask;

   // Edge bits: set beats clear when both occur in one cycle.
   always_comb begin
      pending_nxt = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (edge_sel[i]) pending_nxt[i] = (pending[i] & ~w1c[i]) | rise[i];
         else             pending_nxt[i] = irq_s[i];
      end
      pending_nxt = pending_nxt & IMPL_MASK;
   end

   irq_prio_enc16 u_prio (
      .req   (masked),
      .idx   (act),
      .valid (act_valid)
   );

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_PENDING: rd_mux = pending;
         ADDR_MASK:    rd_mux = mask;
         ADDR_EDGE:    rd_mux = edge_sel;
         ADDR_ACTIVE: begin
            rd_mux[3:0]           = act;
            rd_mux[ACT_VALID_BIT] = act_valid;
         end
         ADDR_RAW:     rd_mux = irq_s;
         default:      rd_mux = '0;
      endcase
   end

   // Register / output stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_prev     <= '0;
         pending      <= '0;
         mask         <= '0;
         edge_sel     <= EDGE_RESET & IMPL_MASK;
         bus.readdata <= '0;
         irq          <= 1'b0;
      end else begin
         irq_prev     <= irq_s;
         pending      <= pending_nxt;
         bus.readdata <= rd_mux;
         irq          <= |masked;
         if (wr_en && bus.address == ADDR_MASK) mask     <= bus.writedata & IMPL_MASK;
         if (wr_en && bus.address == ADDR_EDGE) edge_sel <= bus.writedata & IMPL_MASK;
      end
   end

endmodule

// File: tb/tb_avalon_irq_aggregator.sv
// Directed bench for avalon_irq_aggregator (N_IRQ=8, EDGE_RESET=0).
module tb_avalon_irq_aggregator;
   import avalon_irq_aggregator_pkg::*;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic       clk;
   logic       reset_n;
   logic [7:0] irq_in;
   logic       irq;
   int         n_checks;
   int         n_err;

   avalon_irq_aggregator_if bus ();

   avalon_irq_aggregator #(
      .N_IRQ      (8),
      .EDGE_RESET (16'h0000)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .irq_in  (irq_in),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      tick();
      bus.chipselect = 1'b0;
      check(tag, bus.readdata, exp);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   initial begin
      n_checks       = 0;
      n_err          = 0;
      reset_n        = 1'b0;
      irq_in         = 8'h00;
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 16'h0000;
      repeat (3) tick();
      check("reset_irq", {15'd0, irq}, 16'h0000);
      check("reset_readdata", bus.readdata, 16'h0000);
      reset_n = 1'b1;
      tick();

      rd(3'd0, "rst_pending", 16'h0000);
      rd(3'd1, "rst_mask",    16'h0000);
      rd(3'd2, "rst_edge",    16'h0000);
      rd(3'd3, "rst_active",  16'h0000);
      rd(3'd4, "rst_raw",     16'h0000);
      rd(3'd7, "rst_addr7",   16'h0000);
      check("rst_irq_after", {15'd0, irq}, 16'h0000);

      // Level mode on bit 0
      wr(3'd1, 16'h0001);
      irq_in[0] = 1'b1;
      repeat (LAT - 1) tick();
      check("lvl_irq_early", {15'd0, irq}, 16'h0000);
      tick();
      check("lvl_irq_rise", {15'd0, irq}, 16'h0001);
      rd(3'd3, "lvl_active", 16'h8000);
      rd(3'd4, "lvl_raw",    16'h0001);
      wr(3'd0, 16'h0001);
      rd(3'd0, "lvl_w1c_noeffect", 16'h0001);
      check("lvl_irq_held", {15'd0, irq}, 16'h0001);
      irq_in[0] = 1'b0;
      repeat (LAT - 1) tick();
      check("lvl_irq_fall_early", {15'd0, irq}, 16'h0001);
      tick();
      check("lvl_irq_fall", {15'd0, irq}, 16'h0000);
      rd(3'd0, "lvl_pending_clr", 16'h0000);

      // Edge mode on bit 2
      wr(3'd2, 16'h0004);
      wr(3'd1, 16'h0004);
      irq_in[2] = 1'b1;
      tick();
      irq_in[2] = 1'b0;
      repeat (LAT - 2) tick();
      check("edge_irq_early", {15'd0, irq}, 16'h0000);
      tick();
      check("edge_irq_rise", {15'd0, irq}, 16'h0001);
      repeat (4) tick();
      check("edge_irq_hold", {15'd0, irq}, 16'h0001);
      rd(3'd0, "edge_pending", 16'h0004);
      rd(3'd3, "edge_active",  16'h8002);
      wr(3'd0, 16'h0004);
      check("edge_irq_after_w1c", {15'd0, irq}, 16'h0001);
      tick();
      check("edge_irq_cleared", {15'd0, irq}, 16'h0000);
      rd(3'd0, "edge_pending_clr", 16'h0000);

      // Set/clear collision on edge bit 1
      wr(3'd2, 16'h0006);
      wr(3'd1, 16'h0002);
      irq_in[1] = 1'b1;
      tick();
      irq_in[1] = 1'b0;
      repeat (LAT) tick();
      check("coll_irq_before", {15'd0, irq}, 16'h0001);
      irq_in[1] = 1'b1;
      repeat (LAT - 2) tick();
      irq_in[1] = 1'b0;
      wr(3'd0, 16'h0002);
      rd(3'd0, "coll_pending", 16'h0002);
      tick();
      check("coll_irq_after", {15'd0, irq}, 16'h0001);
      wr(3'd0, 16'h0002);
      tick();
      check("coll_irq_cleared", {15'd0, irq}, 16'h0000);

      // Priority between bits 3 and 5
      wr(3'd2, 16'h0028);
      wr(3'd1, 16'h0028);
      irq_in = 8'h28;
      tick();
      irq_in = 8'h00;
      repeat (LAT) tick();
      rd(3'd0, "prio_pending", 16'h0028);
      rd(3'd3, "prio_active_3", 16'h8003);
      wr(3'd1, 16'h0020);
      rd(3'd3, "prio_active_5", 16'h8005);
      wr(3'd1, 16'h0000);
      rd(3'd3, "prio_active_none", 16'h0000);
      check("prio_irq_off", {15'd0, irq}, 16'h0000);
      wr(3'd1, 16'hFF00);
      rd(3'd1, "mask_upper_dropped", 16'h0000);
      wr(3'd3, 16'hFFFF);
      rd(3'd3, "active_write_ignored", 16'h0000);

      // Reset mid-operation
      wr(3'd2, 16'h00FF);
      wr(3'd1, 16'h00FF);
      irq_in = 8'hFF;
      tick();
      irq_in = 8'h00;
      repeat (LAT) tick();
      check("mid_irq_on", {15'd0, irq}, 16'h0001);
      rd(3'd0, "mid_pending", 16'h00FF);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_irq", {15'd0, irq}, 16'h0000);
      check("mid_rst_readdata", bus.readdata, 16'h0000);
      tick();
      reset_n = 1'b1;
      rd(3'd0, "post_pending", 16'h0000);
      rd(3'd1, "post_mask",    16'h0000);
      rd(3'd2, "post_edge",    16'h0000);
      check("post_irq", {15'd0, irq}, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
